pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 22 ++
 rtl/mux2to1_32b.sv | 18 +
 rtl/pc_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit_pkg
// Shared processor definitions used by the instruction fetch stage:
//   - fetch_state_e : fetch controller state encoding (FETCH / HOLD / DRAIN)
//   - DEFAULT_RESET_PC : first fetch address after reset
//   - NOP_WORD : canonical no-operation instruction word
//   - PC_STEP / PC_ALIGN_MASK : sequential increment and word-alignment mask
// ----------------------------------------------------------------------------
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding (or about to be) at pc
        HOLD  = 2'd1,   // word returned during a stall, parked in hold buffer
        DRAIN = 2'd2    // redirected while a request was in flight; swallow it
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'hE1A0_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage : pc_fetch_unit_pkg

// File: rtl/mux2to1_32b.sv
// ----------------------------------------------------------------------------
// mux2to1_32b
// Plain 32-bit two-input multiplexer.
//   i0  : selected when sel = 0
//   i1  : selected when sel = 1
//   sel : select
//   y   : result
// ----------------------------------------------------------------------------
module mux2to1_32b (
    input  logic [31:0] i0,
    input  logic [31:0] i1,
    input  logic        sel,
    output logic [31:0] y
);

    assign y = sel ? i1 : i0;

endmodule : mux2to1_32b

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
// Instruction fetch stage: owns the PC, issues one word request at a time to
// instruction memory and fills the IF/ID register.
//   clk, rst_n            : clock, asynchronous active-low reset
//   branch_taken/addr     : redirect from execute (addr bits [1:0] ignored)
//   freeze                : decode stall; holds IF/ID and the PC
//   imem_req/addr         : memory request, held stable until imem_ack
//   imem_ack/rdata        : completion; rdata valid in the ack cycle
//   if_valid/pc/instr     : IF/ID register (if_pc = fetch address + 4)
// ----------------------------------------------------------------------------
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        freeze,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [31:0]  hold_q, hold_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    // Keeps imem_req low through reset and for the edge that releases it.
    logic         req_en_q, req_en_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;
    logic         ack_valid;

    assign pc_plus4 = pc_q + PC_STEP;

    mux2to1_32b u_next_pc_mux (
        .i0  (pc_plus4),
        .i1  (branch_addr & PC_ALIGN_MASK),
        .sel (branch_taken),
        .y   (next_pc)
    );

    // An ack only counts while a request is actually being presented.
    assign ack_valid = imem_ack & imem_req;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        hold_d       = hold_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        req_en_d     = 1'b1;

        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    pc_d       = next_pc;
                    if_valid_d = 1'b0;
                    if (imem_req && !imem_ack) begin
                        // Request still in flight: remember its address and drain it.
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (ack_valid && freeze) begin
                    hold_d  = imem_rdata;
                    state_d = HOLD;
                end else if (ack_valid) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_plus4;
                    if_instr_d = imem_rdata;
                    pc_d       = next_pc;
                end else if (!freeze) begin
                    // Decode consumed the previous word and nothing new arrived.
                    if_valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    pc_d       = next_pc;
                    if_valid_d = 1'b0;
                    hold_d     = '0;
                    state_d    = FETCH;
                end else if (!freeze) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_plus4;
                    if_instr_d = hold_q;
                    pc_d       = next_pc;
                    state_d    = FETCH;
                end
            end

            DRAIN: begin
                // Returned data is dropped; a later branch just retargets the pc.
                if (branch_taken) begin
                    pc_d = next_pc;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            hold_q       <= '0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
            req_en_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge _d values.
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            hold_q       <= hold_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            req_en_q     <= req_en_d;
        end
    end

    assign imem_req  = req_en_q && (state_q != HOLD);
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed scenarios with literal expectations, then randomized traffic
// (branches, stalls, acks, occasional async resets). A behavioural model of
// the fetch stage predicts the outputs of the main instance every cycle.
// A second instance with RESET_PC = 32'hFFFF_FFFC exercises PC wrap-around.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        freeze;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic        b_req;
    logic [31:0] b_addr;
    logic        b_valid;
    logic [31:0] b_pc;
    logic [31:0] b_instr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .freeze       (freeze),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .freeze       (freeze),
        .imem_req     (b_req),
        .imem_addr    (b_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_valid     (b_valid),
        .if_pc        (b_pc),
        .if_instr     (b_instr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a PC, whether a stalled word is parked, whether an
    // abandoned request is still being waited out, and the IF/ID contents.
    // ------------------------------------------------------------------
    logic [31:0] m_pc;
    logic        m_started;     // requests only begin one edge after reset
    logic        m_holding;
    logic [31:0] m_held;
    logic        m_draining;
    logic [31:0] m_drain_addr;
    logic        m_vld;
    logic [31:0] m_ifpc;
    logic [31:0] m_instr;

    task automatic model_reset();
        m_pc = 32'h0; m_started = 1'b0; m_holding = 1'b0; m_held = 32'h0;
        m_draining = 1'b0; m_drain_addr = 32'h0;
        m_vld = 1'b0; m_ifpc = 32'h0; m_instr = 32'h0;
    endtask

    task automatic deliver(input logic [31:0] word);
        m_vld   = 1'b1;
        m_ifpc  = m_pc + 32'd4;
        m_instr = word;
        m_pc    = m_pc + 32'd4;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        logic        requesting;
        tgt        = branch_addr & 32'hFFFF_FFFC;
        requesting = m_started && !m_holding;
        if (m_draining) begin
            if (branch_taken) m_pc = tgt;
            if (imem_ack) m_draining = 1'b0;
        end else if (m_holding) begin
            if (branch_taken) begin
                m_pc = tgt; m_vld = 1'b0; m_holding = 1'b0;
            end else if (!freeze) begin
                deliver(m_held);
                m_holding = 1'b0;
            end
        end else begin
            if (branch_taken) begin
                if (requesting && !imem_ack) begin
                    m_draining   = 1'b1;
                    m_drain_addr = m_pc;
                end
                m_pc  = tgt;
                m_vld = 1'b0;
            end else if (requesting && imem_ack && freeze) begin
                m_held    = imem_rdata;
                m_holding = 1'b1;
            end else if (requesting && imem_ack) begin
                deliver(imem_rdata);
            end else if (!freeze) begin
                m_vld = 1'b0;
            end
        end
        m_started = 1'b1;
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Compare process: outputs depend only on registered state, so the
    // falling edge sees them settled.
    always @(negedge clk) begin
        check("model_req",   {31'b0, imem_req}, {31'b0, m_started && !m_holding});
        check("model_addr",  imem_addr, m_draining ? m_drain_addr : m_pc);
        check("model_valid", {31'b0, if_valid}, {31'b0, m_vld});
        check("model_if_pc", if_pc, m_ifpc);
        check("model_instr", if_instr, m_instr);
    end

    task automatic drive(input logic br, input logic [31:0] ba, input logic frz,
                         input logic ack, input logic [31:0] rd);
        branch_taken = br;
        branch_addr  = ba;
        freeze       = frz;
        imem_ack     = ack;
        imem_rdata   = rd;
    endtask

    initial begin
        logic [31:0] w;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);

        // Reset release, ack every cycle: 0,4,8,... and if_pc 4,8,12,...
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h1000_0000);
        @(negedge clk);
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        check("wrap_first_addr", b_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) begin
            w = 32'hA000_0000 + 32'(i);
            drive(1'b0, 32'h0, 1'b0, 1'b1, w);
            @(negedge clk);
            check("seq_addr", imem_addr, 32'(4 * (i + 1)));
            check("seq_if_pc", if_pc, 32'(4 * (i + 1)));
            check("seq_instr", if_instr, w);
            if (i == 0) begin
                check("wrap_addr", b_addr, 32'h0);
                check("wrap_if_pc", b_pc, 32'h0);
                check("wrap_valid", {31'b0, b_valid}, 32'd1);
                check("wrap_instr", b_instr, w);
                check("wrap_req", {31'b0, b_req}, 32'd1);
            end
        end

        // Freeze for 3 cycles coincident with the ack of 0x10.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hC0DE_0010);
        @(negedge clk);
        check("hold_req", {31'b0, imem_req}, 32'd0);
        check("hold_if_pc", if_pc, 32'h10);
        check("hold_instr", if_instr, 32'hA000_0003);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, $urandom);
            @(negedge clk);
            check("hold_req_k", {31'b0, imem_req}, 32'd0);
            check("hold_if_pc_k", if_pc, 32'h10);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("unfreeze_instr", if_instr, 32'hC0DE_0010);
        check("unfreeze_if_pc", if_pc, 32'h14);
        check("unfreeze_addr", imem_addr, 32'h14);
        check("unfreeze_req", {31'b0, imem_req}, 32'd1);

        // Advance to 0x40, then redirect while its request waits two cycles.
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, $urandom);
            @(negedge clk);
        end
        check("pre_branch_addr", imem_addr, 32'h40);
        drive(1'b1, 32'h0000_0203, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("drain_addr", imem_addr, 32'h40);
        check("drain_req", {31'b0, imem_req}, 32'd1);
        check("drain_valid", {31'b0, if_valid}, 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("drain_addr_2", imem_addr, 32'h40);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("after_drain_addr", imem_addr, 32'h200);
        check("after_drain_valid", {31'b0, if_valid}, 32'd0);

        // Branch and freeze together while in HOLD.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h5555_0200);
        @(negedge clk);
        check("hold2_req", {31'b0, imem_req}, 32'd0);
        drive(1'b1, 32'h0000_0103, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("hold_br_valid", {31'b0, if_valid}, 32'd0);
        check("hold_br_addr", imem_addr, 32'h100);
        check("hold_br_req", {31'b0, imem_req}, 32'd1);

        // Async reset while a request is waiting.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("wait_addr", imem_addr, 32'h100);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", {31'b0, imem_req}, 32'd0);
        check("async_addr", imem_addr, 32'h0);
        check("async_valid", {31'b0, if_valid}, 32'd0);
        check("async_if_pc", if_pc, 32'h0);
        check("async_instr", if_instr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h7);
        @(negedge clk);
        check("restart_addr", imem_addr, 32'h0);
        check("restart_req", {31'b0, imem_req}, 32'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom % 6) == 0, $urandom, ($urandom % 4) == 0,
                  ($urandom % 3) != 0, $urandom);
            if (($urandom % 500) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #3 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pc_fetch_unit
